// File: rtl/mutex_client_master_if.sv
// Avalon-MM command/response bundle between the mutex client
// master and the interconnect (mutex slave side).
interface mutex_client_master_if;
  logic        avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/mutex_client_master.sv
// Acquire/release engine for one hardware mutex slave:
// write {owner,value}, read back, compare, back off and retry.
module mutex_client_master #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic acq_req,
  input  logic rel_req,
  output logic busy,
  output logic granted,
  output logic done,
  output logic fail,
  mutex_client_master_if.master avm
);

  typedef enum logic [2:0] {
    IDLE, ACQ_WR, ACQ_RD, CHECK, BACKOFF, REL_WR
  } state_t;

  localparam logic [31:0] LOCK_WORD = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] FREE_WORD = {OWNER_ID, 16'h0000};
  localparam logic [15:0] BO_LOAD   = 16'(BACKOFF_CYCLES);
  localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRIES);

  state_t      state;
  logic [15:0] retry_cnt;
  logic [15:0] bo_cnt;
  logic [31:0] rd_q;
  logic [15:0] retry_nxt;
  logic        accept;

  // Saturate so retry-forever never wraps back to a small count.
  assign retry_nxt = (retry_cnt == 16'hffff) ? retry_cnt
                                             : retry_cnt + 16'd1;
  assign accept = !avm.avm_waitrequest;
  assign avm.avm_address = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      retry_cnt          <= '0;
      bo_cnt             <= '0;
      rd_q               <= '0;
      busy               <= 1'b0;
      granted            <= 1'b0;
      done               <= 1'b0;
      fail               <= 1'b0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_read       <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_writedata  <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rel_req && granted) begin
            state              <= REL_WR;
            busy               <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write      <= 1'b1;
            avm.avm_writedata  <= FREE_WORD;
          end else if (acq_req && !granted) begin
            state              <= ACQ_WR;
            busy               <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write      <= 1'b1;
            avm.avm_writedata  <= LOCK_WORD;
          end else if (acq_req || rel_req) begin
            done <= 1'b1;
          end
        end
        ACQ_WR: begin
          if (accept) begin
            state         <= ACQ_RD;
            avm.avm_write <= 1'b0;
            avm.avm_read  <= 1'b1;
          end
        end
        ACQ_RD: begin
          if (accept) begin
            state              <= CHECK;
            rd_q               <= avm.avm_readdata;
            avm.avm_chipselect <= 1'b0;
            avm.avm_read       <= 1'b0;
          end
        end
        CHECK: begin
          if (rd_q == LOCK_WORD) begin
            state     <= IDLE;
            busy      <= 1'b0;
            granted   <= 1'b1;
            done      <= 1'b1;
            retry_cnt <= '0;
          end else if (RETRY_MAX != 16'd0 &&
                       retry_nxt == RETRY_MAX) begin
            state     <= IDLE;
            busy      <= 1'b0;
            fail      <= 1'b1;
            retry_cnt <= '0;
          end else begin
            state     <= BACKOFF;
            retry_cnt <= retry_nxt;
            bo_cnt    <= BO_LOAD;
          end
        end
        BACKOFF: begin
          if (bo_cnt == 16'd1) begin
            state              <= ACQ_WR;
            bo_cnt             <= '0;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write      <= 1'b1;
            avm.avm_writedata  <= LOCK_WORD;
          end else begin
            bo_cnt <= bo_cnt - 16'd1;
          end
        end
        REL_WR: begin
          if (accept) begin
            state              <= IDLE;
            busy               <= 1'b0;
            granted            <= 1'b0;
            done               <= 1'b1;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_client_master.sv
// Scoreboard bench: mutex slave model, expected bus transfers
// and done/fail events queued by stimulus, popped by a monitor.
module tb_mutex_client_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic acq_req = 1'b0;
  logic rel_req = 1'b0;
  logic busy, granted, done, fail;

  mutex_client_master_if bus();

  mutex_client_master #(
    .OWNER_ID(16'h0001),
    .LOCK_VALUE(16'h0001),
    .BACKOFF_CYCLES(4),
    .MAX_RETRIES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .acq_req(acq_req),
    .rel_req(rel_req),
    .busy(busy),
    .granted(granted),
    .done(done),
    .fail(fail),
    .avm(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Mutex slave: a write takes effect only when the lock is free or
  // already owned by the writer; "foreign" means owner 5 holds it.
  logic [31:0] mem = '0;
  bit foreign = 1'b0;
  int rel_after = -1;
  int ww = 0, rw = 0, wcnt = 0;
  bit ld = 1'b0, ld_foreign = 1'b0;
  int ld_rel = -1;

  assign bus.avm_readdata = foreign ? 32'h00050007 : mem;
  assign bus.avm_waitrequest = bus.avm_chipselect &&
    ((bus.avm_write && wcnt < ww) || (bus.avm_read && wcnt < rw));

  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (ld) begin
      foreign   <= ld_foreign;
      rel_after <= ld_rel;
      mem       <= '0;
    end else if (bus.avm_chipselect && !bus.avm_waitrequest) begin
      if (bus.avm_write && !foreign &&
          (mem[15:0] == 16'h0 || mem[31:16] == bus.avm_writedata[31:16]))
        mem <= bus.avm_writedata;
      if (bus.avm_read && foreign && rel_after > 0) begin
        if (rel_after == 1) foreign <= 1'b0;
        rel_after <= rel_after - 1;
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int          gap;
  } bus_t;
  typedef struct {
    bit is_fail;
    int at;
  } ev_t;

  bus_t bq[$];
  ev_t  eq[$];
  int   last_rd = 0;
  bit   stall_prev = 1'b0;
  logic [35:0] held;

  always @(negedge clk) begin
    bus_t b;
    ev_t  e;
    if (stall_prev)
      chk("cmd_stable", {bus.avm_address, bus.avm_chipselect,
          bus.avm_read, bus.avm_write, bus.avm_writedata}, held);
    stall_prev = bus.avm_chipselect && bus.avm_waitrequest && reset_n;
    held = {bus.avm_address, bus.avm_chipselect, bus.avm_read,
            bus.avm_write, bus.avm_writedata};
    if (bus.avm_chipselect) begin
      chk("rd_wr_excl", bus.avm_read & bus.avm_write, 0);
    end
    if (bus.avm_chipselect && !bus.avm_waitrequest) begin
      if (bq.size() == 0) begin
        chk("unexpected_xfer", {bus.avm_write, bus.avm_writedata}, 0);
      end else begin
        b = bq.pop_front();
        chk("xfer_kind", {bus.avm_address, bus.avm_write},
            {1'b0, b.wr});
        if (b.wr) chk("wdata", bus.avm_writedata, b.data);
        if (b.wr && b.gap >= 0)
          chk("backoff_gap", cyc - last_rd - 1, b.gap);
        if (!b.wr) last_rd = cyc;
      end
    end
    if (done || fail) begin
      chk("done_fail_excl", done & fail, 0);
      if (eq.size() == 0) begin
        chk("unexpected_event", {done, fail}, 0);
      end else begin
        e = eq.pop_front();
        chk("event_kind", fail, e.is_fail);
        chk("event_cycle", cyc, e.at);
      end
    end
  end

  task automatic pulse(bit a, bit r, output int c0);
    @(posedge clk); #1;
    acq_req = a;
    rel_req = r;
    c0 = cyc;
    @(posedge clk); #1;
    acq_req = 1'b0;
    rel_req = 1'b0;
  endtask

  task automatic preload(bit f, int r);
    @(posedge clk); #1;
    ld = 1'b1;
    ld_foreign = f;
    ld_rel = r;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic drain(int n, string name);
    repeat (n) @(posedge clk);
    #1;
    chk({name, "_bus_left"}, bq.size(), 0);
    chk({name, "_ev_left"}, eq.size(), 0);
    bq.delete();
    eq.delete();
  endtask

  task automatic chk_reset(string name);
    @(negedge clk);
    chk(name, {busy, granted, done, fail, bus.avm_chipselect,
        bus.avm_read, bus.avm_write, bus.avm_address,
        bus.avm_writedata}, 0);
  endtask

  task automatic push_attempt(int gap);
    bq.push_back('{1'b1, 32'h00010001, gap});
    bq.push_back('{1'b0, 32'h0, -1});
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    chk_reset("reset_state");
    #1 reset_n = 1'b1;

    // Free mutex: write, read, done at cycle 4.
    preload(0, -1);
    push_attempt(-1);
    pulse(1, 0, c0);
    eq.push_back('{1'b0, c0 + 4});
    drain(8, "acq_free");
    chk("acq_free_granted", {granted, busy}, 2'b10);

    // Already granted: done next cycle, no bus traffic.
    pulse(1, 0, c0);
    eq.push_back('{1'b0, c0 + 1});
    drain(4, "acq_held");
    chk("acq_held_granted", granted, 1);

    bq.push_back('{1'b1, 32'h00010000, -1});
    pulse(0, 1, c0);
    eq.push_back('{1'b0, c0 + 2});
    drain(4, "release");
    chk("release_granted", granted, 0);

    pulse(0, 1, c0);
    eq.push_back('{1'b0, c0 + 1});
    drain(4, "rel_free");
    chk("rel_free_granted", granted, 0);

    // 5 stall cycles on the write, 3 on the read.
    ww = 5;
    rw = 3;
    push_attempt(-1);
    pulse(1, 0, c0);
    eq.push_back('{1'b0, c0 + 12});
    drain(16, "waitreq");
    chk("waitreq_granted", granted, 1);
    ww = 0;
    rw = 0;
    bq.push_back('{1'b1, 32'h00010000, -1});
    pulse(0, 1, c0);
    eq.push_back('{1'b0, c0 + 2});
    drain(4, "waitreq_rel");

    // Owner 5 releases after 3 reads; gap is CHECK plus 4 backoff.
    preload(1, 3);
    push_attempt(-1);
    for (int i = 0; i < 3; i++) push_attempt(5);
    pulse(1, 0, c0);
    eq.push_back('{1'b0, c0 + 25});
    drain(32, "contend");
    chk("contend_granted", granted, 1);
    bq.push_back('{1'b1, 32'h00010000, -1});
    pulse(0, 1, c0);
    eq.push_back('{1'b0, c0 + 2});
    drain(4, "contend_rel");

    // Held forever: 4 attempts then fail.
    preload(1, -1);
    push_attempt(-1);
    for (int i = 0; i < 3; i++) push_attempt(5);
    pulse(1, 0, c0);
    eq.push_back('{1'b1, c0 + 25});
    drain(32, "give_up");
    chk("give_up_state", {granted, busy}, 0);

    // Simultaneous acq&rel while granted: release wins.
    preload(0, -1);
    push_attempt(-1);
    pulse(1, 0, c0);
    eq.push_back('{1'b0, c0 + 4});
    drain(8, "acq2");
    bq.push_back('{1'b1, 32'h00010000, -1});
    pulse(1, 1, c0);
    eq.push_back('{1'b0, c0 + 2});
    drain(4, "both_req");
    chk("both_req_granted", granted, 0);

    // Reset while stalled in the readback.
    rw = 3;
    bq.push_back('{1'b1, 32'h00010001, -1});
    pulse(1, 0, c0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    chk_reset("reset_in_read");
    #1 reset_n = 1'b1;
    rw = 0;
    drain(4, "reset_in_read");

    // Reset while backing off.
    preload(1, -1);
    push_attempt(-1);
    pulse(1, 0, c0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    chk_reset("reset_in_backoff");
    #1 reset_n = 1'b1;
    drain(4, "reset_in_backoff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
